// File: rtl/motion_frame_stats.sv
// motion_frame_stats: per-frame class counts, foreground bounding box and a
// debounced motion alarm, computed from a raster-order 2-bit class stream.
module motion_frame_stats #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int N_ON     = 2,
    parameter int N_OFF    = 4,
    parameter int CW       = $clog2(H_ACTIVE * V_ACTIVE + 1),
    parameter int XW       = $clog2(H_ACTIVE),
    parameter int YW       = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    classification,
    input  logic          class_valid,
    input  logic          frame_sync,
    input  logic [CW-1:0] fg_threshold,
    output logic [CW-1:0] fg_count,
    output logic [CW-1:0] shadow_count,
    output logic [CW-1:0] highlight_count,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max,
    output logic          bbox_valid,
    output logic          motion_frame,
    output logic          alarm,
    output logic          stats_valid
);

    localparam int SMAX = (N_ON > N_OFF) ? N_ON : N_OFF;
    localparam int SW   = $clog2(SMAX + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic {QUIET = 1'b0, ACTIVE = 1'b1} state_t;

    state_t          r_state, w_state_nx;
    logic [SW-1:0]   r_streak, w_streak_nx, w_streak_inc;

    logic [XW-1:0]   r_x, w_x_base, w_x_nx;
    logic [YW-1:0]   r_y, w_y_base, w_y_nx;
    logic [CW-1:0]   r_acc_fg, r_acc_sh, r_acc_hl;
    logic [CW-1:0]   w_fg_nx, w_sh_nx, w_hl_nx;
    logic            r_seen, w_seen_base, w_seen_nx;
    logic [XW-1:0]   r_xmin, r_xmax, w_xmin_nx, w_xmax_nx;
    logic [YW-1:0]   r_ymin, r_ymax, w_ymin_nx, w_ymax_nx;
    logic            w_pix_fg, w_pix_sh, w_pix_hl;
    logic            w_last, w_motion;

    assign w_pix_fg = class_valid && (classification == 2'b01);
    assign w_pix_sh = class_valid && (classification == 2'b10);
    assign w_pix_hl = class_valid && (classification == 2'b11);
    // frame_sync wins over a coincident last pixel: no completion that cycle
    assign w_last   = class_valid && !frame_sync && (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_motion = (w_fg_nx >= fg_threshold);
    assign alarm    = (r_state == ACTIVE);

    // Next position, accumulators and bbox including the current pixel;
    // frame_sync makes the current pixel (0,0) of a fresh frame.
    always_comb begin
        w_x_base    = frame_sync ? '0 : r_x;
        w_y_base    = frame_sync ? '0 : r_y;
        w_seen_base = frame_sync ? 1'b0 : r_seen;
        w_fg_nx     = (frame_sync ? '0 : r_acc_fg) + CW'(w_pix_fg);
        w_sh_nx     = (frame_sync ? '0 : r_acc_sh) + CW'(w_pix_sh);
        w_hl_nx     = (frame_sync ? '0 : r_acc_hl) + CW'(w_pix_hl);
        w_x_nx      = w_x_base;
        w_y_nx      = w_y_base;
        if (class_valid) begin
            if (w_x_base == X_LAST) begin
                w_x_nx = '0;
                w_y_nx = (w_y_base == Y_LAST) ? '0 : w_y_base + 1'b1;
            end else begin
                w_x_nx = w_x_base + 1'b1;
            end
        end
        w_xmin_nx = frame_sync ? '0 : r_xmin;
        w_xmax_nx = frame_sync ? '0 : r_xmax;
        w_ymin_nx = frame_sync ? '0 : r_ymin;
        w_ymax_nx = frame_sync ? '0 : r_ymax;
        if (w_pix_fg) begin
            if (!w_seen_base) begin
                w_xmin_nx = w_x_base;
                w_xmax_nx = w_x_base;
                w_ymin_nx = w_y_base;
                w_ymax_nx = w_y_base;
            end else begin
                if (w_x_base < w_xmin_nx) w_xmin_nx = w_x_base;
                if (w_x_base > w_xmax_nx) w_xmax_nx = w_x_base;
                if (w_y_base < w_ymin_nx) w_ymin_nx = w_y_base;
                if (w_y_base > w_ymax_nx) w_ymax_nx = w_y_base;
            end
        end
        w_seen_nx = w_seen_base | w_pix_fg;
    end

    // Running frame state plus the output latch at frame completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x             <= '0;
            r_y             <= '0;
            r_acc_fg        <= '0;
            r_acc_sh        <= '0;
            r_acc_hl        <= '0;
            r_seen          <= 1'b0;
            r_xmin          <= '0;
            r_xmax          <= '0;
            r_ymin          <= '0;
            r_ymax          <= '0;
            fg_count        <= '0;
            shadow_count    <= '0;
            highlight_count <= '0;
            x_min           <= '0;
            x_max           <= '0;
            y_min           <= '0;
            y_max           <= '0;
            bbox_valid      <= 1'b0;
            motion_frame    <= 1'b0;
            stats_valid     <= 1'b0;
        end else begin
            r_x         <= w_x_nx;
            r_y         <= w_y_nx;
            r_xmin      <= w_xmin_nx;
            r_xmax      <= w_xmax_nx;
            r_ymin      <= w_ymin_nx;
            r_ymax      <= w_ymax_nx;
            stats_valid <= w_last;
            if (w_last) begin
                r_acc_fg        <= '0;
                r_acc_sh        <= '0;
                r_acc_hl        <= '0;
                r_seen          <= 1'b0;
                fg_count        <= w_fg_nx;
                shadow_count    <= w_sh_nx;
                highlight_count <= w_hl_nx;
                x_min           <= w_seen_nx ? w_xmin_nx : '0;
                x_max           <= w_seen_nx ? w_xmax_nx : '0;
                y_min           <= w_seen_nx ? w_ymin_nx : '0;
                y_max           <= w_seen_nx ? w_ymax_nx : '0;
                bbox_valid      <= w_seen_nx;
                motion_frame    <= w_motion;
            end else begin
                r_acc_fg <= w_fg_nx;
                r_acc_sh <= w_sh_nx;
                r_acc_hl <= w_hl_nx;
                r_seen   <= w_seen_nx;
            end
        end
    end

    // Alarm state and streak register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= QUIET;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_streak <= w_streak_nx;
        end
    end

    // Alarm debounce: advances only on a completed frame.
    always_comb begin
        w_state_nx   = r_state;
        w_streak_nx  = r_streak;
        w_streak_inc = r_streak + 1'b1;
        if (w_last) begin
            case (r_state)
                QUIET: begin
                    if (w_motion) begin
                        if (w_streak_inc == SW'(N_ON)) begin
                            w_state_nx  = ACTIVE;
                            w_streak_nx = '0;
                        end else begin
                            w_streak_nx = w_streak_inc;
                        end
                    end else begin
                        w_streak_nx = '0;
                    end
                end
                ACTIVE: begin
                    if (!w_motion) begin
                        if (w_streak_inc == SW'(N_OFF)) begin
                            w_state_nx  = QUIET;
                            w_streak_nx = '0;
                        end else begin
                            w_streak_nx = w_streak_inc;
                        end
                    end else begin
                        w_streak_nx = '0;
                    end
                end
                default: begin
                    w_state_nx  = QUIET;
                    w_streak_nx = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_frame_stats.sv
// Scoreboard bench for motion_frame_stats on a reduced frame size.
module tb_motion_frame_stats;

    localparam int H     = 24;
    localparam int V     = 12;
    localparam int NPIX  = H * V;
    localparam int N_ON  = 2;
    localparam int N_OFF = 4;
    localparam int CW    = $clog2(NPIX + 1);
    localparam int XW    = $clog2(H);
    localparam int YW    = $clog2(V);

    logic          clk;
    logic          rst;
    logic [1:0]    classification;
    logic          class_valid;
    logic          frame_sync;
    logic [CW-1:0] fg_threshold;
    logic [CW-1:0] fg_count, shadow_count, highlight_count;
    logic [XW-1:0] x_min, x_max;
    logic [YW-1:0] y_min, y_max;
    logic          bbox_valid, motion_frame, alarm, stats_valid;

    motion_frame_stats #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .N_ON(N_ON),
        .N_OFF(N_OFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .classification(classification),
        .class_valid(class_valid),
        .frame_sync(frame_sync),
        .fg_threshold(fg_threshold),
        .fg_count(fg_count),
        .shadow_count(shadow_count),
        .highlight_count(highlight_count),
        .x_min(x_min),
        .x_max(x_max),
        .y_min(y_min),
        .y_max(y_max),
        .bbox_valid(bbox_valid),
        .motion_frame(motion_frame),
        .alarm(alarm),
        .stats_valid(stats_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     fg, sh, hl, xmin, xmax, ymin, ymax, bv, mf, al;
        longint cyc;
    } exp_t;

    exp_t   sbq[$];
    exp_t   held;
    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    bit     rst_q    = 1'b0;

    // reference model state
    int     p = 0;
    int     frame[NPIX];
    int     pat[NPIX];
    bit     m_alarm = 1'b0;
    bit     hist[$];
    int     thr = 0;

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
        end
    endfunction

    // Frame statistics computed from the stored frame contents.
    function automatic void complete(int t);
        exp_t e;
        int   xmn, xmx, ymn, ymx, x, y;
        bit   all;
        e   = zero_exp();
        xmn = H; xmx = -1; ymn = V; ymx = -1;
        for (int i = 0; i < NPIX; i++) begin
            x = i % H;
            y = i / H;
            case (frame[i])
                1: begin
                    e.fg++;
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
                2: e.sh++;
                3: e.hl++;
                default: ;
            endcase
        end
        e.bv = (e.fg > 0);
        if (e.bv != 0) begin
            e.xmin = xmn; e.xmax = xmx; e.ymin = ymn; e.ymax = ymx;
        end
        e.mf = (e.fg >= t);
        // alarm: streak since the last transition, held as a history list
        hist.push_back(e.mf[0]);
        if (!m_alarm && hist.size() >= N_ON) begin
            all = 1'b1;
            for (int k = 0; k < N_ON; k++) if (!hist[hist.size()-1-k]) all = 1'b0;
            if (all) begin m_alarm = 1'b1; hist.delete(); end
        end else if (m_alarm && hist.size() >= N_OFF) begin
            all = 1'b1;
            for (int k = 0; k < N_OFF; k++) if (hist[hist.size()-1-k]) all = 1'b0;
            if (all) begin m_alarm = 1'b0; hist.delete(); end
        end
        e.al  = m_alarm;
        e.cyc = cyc + 1;
        sbq.push_back(e);
    endfunction

    task automatic drive(bit v, int cls, bit sync);
        @(posedge clk);
        #1;
        class_valid    = v;
        classification = 2'(cls);
        frame_sync     = sync;
        fg_threshold   = CW'(thr);
        if (sync) p = 0;
        if (v) begin
            frame[p] = cls;
            if (p == NPIX - 1) begin
                complete(thr);
                p = 0;
            end else begin
                p++;
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    // Send pat[] with random gaps; a frame_sync rides on index sync_idx.
    task automatic send_pat(int gap_pct, int sync_idx);
        for (int i = 0; i < NPIX; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(1'b0, 0, 1'b0);
            drive(1'b1, pat[i], (i == sync_idx));
        end
    endtask

    task automatic fill_bg();
        for (int i = 0; i < NPIX; i++) pat[i] = 0;
    endtask

    // Random non-foreground frame with exactly k foreground pixels.
    task automatic make_frame(int k);
        int placed, idx;
        for (int i = 0; i < NPIX; i++) begin
            idx = $urandom_range(2);
            pat[i] = (idx == 0) ? 0 : idx + 1;
        end
        placed = 0;
        while (placed < k) begin
            idx = $urandom_range(NPIX - 1);
            if (pat[idx] != 1) begin
                pat[idx] = 1;
                placed++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        class_valid = 1'b0;
        frame_sync  = 1'b0;
        p           = 0;
        m_alarm     = 1'b0;
        hist.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q = rst;
    end

    // Monitor: pops the scoreboard on each stats_valid and checks held values.
    always @(negedge clk) begin
        bit exp_sv;
        if (rst_q) begin
            held = zero_exp();
            sbq.delete();
        end
        exp_sv = (sbq.size() > 0) && (sbq[0].cyc == cyc);
        chk("stats_valid", 32'(stats_valid), 32'(exp_sv));
        if (exp_sv) held = sbq.pop_front();
        chk("fg_count",        32'(fg_count),        held.fg);
        chk("shadow_count",    32'(shadow_count),    held.sh);
        chk("highlight_count", 32'(highlight_count), held.hl);
        chk("x_min",           32'(x_min),           held.xmin);
        chk("x_max",           32'(x_max),           held.xmax);
        chk("y_min",           32'(y_min),           held.ymin);
        chk("y_max",           32'(y_max),           held.ymax);
        chk("bbox_valid",      32'(bbox_valid),      held.bv);
        chk("motion_frame",    32'(motion_frame),    held.mf);
        chk("alarm",           32'(alarm),           held.al);
    end

    initial begin
        int fgs[12] = '{60, 10, 60, 60, 0, 0, 0, 60, 0, 0, 0, 0};
        int sidx;
        held           = zero_exp();
        rst            = 1'b1;
        class_valid    = 1'b0;
        classification = 2'b00;
        frame_sync     = 1'b0;
        fg_threshold   = '0;
        do_reset();
        idle(2);

        // uniform background
        thr = 1;
        fill_bg();
        send_pat(0, -1);
        idle(3);

        // two-pixel foreground box with shadow/highlight
        fill_bg();
        pat[5*H + 10] = 1;
        pat[9*H + 20] = 1;
        pat[3] = 2; pat[50] = 2; pat[NPIX-2] = 2;
        pat[7] = 3; pat[100] = 3;
        send_pat(0, -1);

        // alarm debounce, back-to-back frames
        thr = 50;
        for (int f = 0; f < 12; f++) begin
            make_frame(fgs[f]);
            send_pat(0, -1);
        end
        idle(2);

        // frame_sync mid-frame, then one background frame
        make_frame(30);
        for (int i = 0; i < 100; i++) drive(1'b1, pat[i], 1'b0);
        drive(1'b0, 0, 1'b1);
        fill_bg();
        send_pat(0, -1);
        idle(2);

        // gapped input with a lone foreground pixel at the last position
        fill_bg();
        pat[NPIX-1] = 1;
        send_pat(30, -1);
        idle(2);

        // raise alarm, then reset mid-frame
        thr = 0;
        make_frame(5);
        send_pat(0, -1);
        make_frame(7);
        send_pat(0, -1);
        make_frame(40);
        for (int i = 0; i < NPIX/2; i++) drive(1'b1, pat[i], 1'b0);
        do_reset();
        thr = 20;
        make_frame(25);
        send_pat(10, -1);

        // randomized frames, including frame_sync on the would-be last pixel
        for (int f = 0; f < 14; f++) begin
            thr = $urandom_range(NPIX / 3);
            make_frame($urandom_range(NPIX / 2));
            if (f == 3)                         sidx = NPIX - 1;
            else if ($urandom_range(3) == 0)    sidx = $urandom_range(NPIX - 1);
            else                                sidx = -1;
            send_pat((f % 2 == 0) ? 0 : 15, sidx);
        end
        // top up any frame left partial by a sync
        fill_bg();
        while (p != 0) drive(1'b1, 0, 1'b0);
        idle(5);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
